// File: rtl/mvtu_pe_array.sv
// mvtu_pe_array: NUM_PE multi-level binarized XNOR-popcount PEs sharing one streamed input vector; MVTU_SATURATE_EN selects a saturating accumulator.
// Latency: out_valid rises 3 cycles after the final beat of a vector is accepted.
// Backpressure: in_ready only while accumulating; the result is held until out_ready and no new beat is taken meanwhile.
module mvtu_pe_array #(
    parameter int NUM_PE    = 4,
    parameter int W_LEVELS  = 2,
    parameter int I_LEVELS  = 2,
    parameter int O_LEVELS  = 2,
    parameter int TWIDTH    = 24,
    parameter int FRAC_BITS = 22,
    parameter int SIMD      = 32,
    parameter int SYN_FOLD  = 18
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [I_LEVELS*SIMD-1:0]             in_data,
    input  logic [NUM_PE*W_LEVELS*SIMD-1:0]      in_weight,
    input  logic [W_LEVELS*TWIDTH-1:0]           w_gamma,
    input  logic [I_LEVELS*TWIDTH-1:0]           i_gamma,
    input  logic [O_LEVELS*TWIDTH-1:0]           o_gamma,
    input  logic [NUM_PE*TWIDTH-1:0]             alpha,
    input  logic [NUM_PE*TWIDTH-1:0]             threshold,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [NUM_PE*O_LEVELS-1:0]           out_bits,
    output logic [NUM_PE*TWIDTH-1:0]             out_fixed
);
    localparam int DW = $clog2(SIMD) + 2;
    localparam int PW = 2 * TWIDTH;
    localparam int SW = PW + DW + $clog2(W_LEVELS * I_LEVELS + 1) + 1;
    localparam int CW = (SYN_FOLD > 1) ? $clog2(SYN_FOLD) : 1;
    localparam int NG = W_LEVELS * I_LEVELS;
    localparam logic signed [TWIDTH-1:0] TMAX = {1'b0, {(TWIDTH-1){1'b1}}};
    localparam logic signed [TWIDTH-1:0] TMIN = {1'b1, {(TWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {ACCUM, SCALE, BIN, OUT} state_t;

    state_t                    state, state_nxt;
    logic [CW-1:0]             beat_cnt;
    logic                      last_beat;
    logic signed [TWIDTH-1:0]  acc      [NUM_PE];
    logic signed [TWIDTH-1:0]  acc_nxt  [NUM_PE];
    logic signed [SW-1:0]      beat_sum [NUM_PE];
    logic signed [SW-1:0]      acc_base [NUM_PE];
    logic signed [SW-1:0]      acc_full [NUM_PE];
    logic signed [SW-1:0]      scaled   [NUM_PE];
    logic signed [PW-1:0]      g        [NG];
    logic signed [SW-1:0]      r;
    logic [NUM_PE*TWIDTH-1:0]  y_pack;
    logic [NUM_PE*O_LEVELS-1:0] bits_pack;

    // Signed +/-1 dot product of one weight level against one input level.
    function automatic logic signed [DW-1:0] xnor_dot(input logic [SIMD-1:0] w, input logic [SIMD-1:0] x);
        logic [DW-1:0] cnt;
        cnt = '0;
        for (int b = 0; b < SIMD; b++) cnt = cnt + DW'(w[b] ~^ x[b]);
        return (cnt << 1) - DW'(SIMD);
    endfunction

    function automatic logic signed [TWIDTH-1:0] clamp(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] hi, lo;
        hi = SW'(TMAX);
        lo = SW'(TMIN);
        if (v > hi)      return TMAX;
        else if (v < lo) return TMIN;
        else             return v[TWIDTH-1:0];
    endfunction

    assign in_ready  = (state == ACCUM);
    assign last_beat = (beat_cnt == CW'(SYN_FOLD - 1));

    always_comb begin
        for (int i = 0; i < W_LEVELS; i++)
            for (int j = 0; j < I_LEVELS; j++)
                g[i*I_LEVELS+j] = (PW'($signed(w_gamma[i*TWIDTH +: TWIDTH])) *
                                   PW'($signed(i_gamma[j*TWIDTH +: TWIDTH]))) >>> FRAC_BITS;
    end

    always_comb begin
        r         = '0;
        y_pack    = '0;
        bits_pack = '0;
        for (int p = 0; p < NUM_PE; p++) begin
            beat_sum[p] = '0;
            for (int i = 0; i < W_LEVELS; i++)
                for (int j = 0; j < I_LEVELS; j++)
                    beat_sum[p] = beat_sum[p] +
                        SW'(xnor_dot(in_weight[(p*W_LEVELS+i)*SIMD +: SIMD], in_data[j*SIMD +: SIMD])) *
                        SW'(g[i*I_LEVELS+j]);
            // Beat 0 starts a fresh vector, so the old accumulator is dropped rather than cleared separately.
            acc_base[p] = (beat_cnt == '0) ? '0 : SW'(acc[p]);
            acc_full[p] = acc_base[p] + beat_sum[p];
`ifdef MVTU_SATURATE_EN
            acc_nxt[p] = clamp(acc_full[p]);
`else
            acc_nxt[p] = acc_full[p][TWIDTH-1:0];
`endif
            scaled[p] = ((SW'(acc[p]) * SW'($signed(alpha[p*TWIDTH +: TWIDTH]))) >>> FRAC_BITS) +
                        SW'($signed(threshold[p*TWIDTH +: TWIDTH]));
            y_pack[p*TWIDTH +: TWIDTH] = clamp(scaled[p]);

            // Residual binarization works on the registered y so BIN sees exactly what out_fixed shows.
            r = SW'($signed(out_fixed[p*TWIDTH +: TWIDTH]));
            for (int k = 0; k < O_LEVELS; k++) begin
                bits_pack[p*O_LEVELS+k] = ~r[SW-1];
                if (!r[SW-1]) r = r - SW'($signed(o_gamma[k*TWIDTH +: TWIDTH]));
                else          r = r + SW'($signed(o_gamma[k*TWIDTH +: TWIDTH]));
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (in_valid && last_beat) state_nxt = SCALE;
            SCALE:   state_nxt = BIN;
            BIN:     state_nxt = OUT;
            OUT:     if (out_valid && out_ready) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ACCUM;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_bits  <= '0;
            out_fixed <= '0;
            for (int p = 0; p < NUM_PE; p++) acc[p] <= '0;
        end else begin
            case (state)
                ACCUM: if (in_valid) begin
                    for (int p = 0; p < NUM_PE; p++) acc[p] <= acc_nxt[p];
                    beat_cnt <= last_beat ? '0 : beat_cnt + CW'(1);
                end
                SCALE: out_fixed <= y_pack;
                BIN:   out_bits  <= bits_pack;
                OUT: begin
                    if (!out_valid)     out_valid <= 1'b1;
                    else if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
